// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, opcodes,
// and the datapath mux / ALU select codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller-to-datapath bundle: instruction fields and flags in, mux selects,
// strobes, memory handshake and status out.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op_i;
  logic [2:0]       funct3_i;
  logic             funct7_i;
  logic             Zero_i;
  logic             mem_ready_i;
  logic             mem_req_o;
  logic             MemWrite_o;
  logic             AdrSrc_o;
  logic             IRWrite_o;
  logic             PCWrite_o;
  logic             RegWrite_o;
  logic [1:0]       ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [2:0]       ALUControl_o;
  logic [2:0]       ImmSrc_o;
  logic [1:0]       ResultSrc_o;
  logic             illegal_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    input  op_i, funct3_i, funct7_i, Zero_i, mem_ready_i,
    output mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
           ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o, ResultSrc_o,
           illegal_o, mem_err_o, instret_o
  );

  modport slave (
    output op_i, funct3_i, funct7_i, Zero_i, mem_ready_i,
    input  mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
           ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o, ResultSrc_o,
           illegal_o, mem_err_o, instret_o
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational funct3/funct7 decode to ALU operation for R and I-arith formats,
// flagging combinations the datapath cannot execute (sra, sltu, R-form funct7 misuse).
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  logic is_r_s;

  // In I-form, instr[30] is an immediate bit except for shifts.
  always_comb begin
    is_r_s   = (op == OP_R);
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct3)
      3'b000: if (is_r_s && funct7) alu_ctrl = ALU_SUB; else alu_ctrl = ALU_ADD;
      3'b001: if (funct7) illegal = 1'b1; else alu_ctrl = ALU_SLL;
      3'b010: if (is_r_s && funct7) illegal = 1'b1; else alu_ctrl = ALU_SLT;
      3'b100: if (is_r_s && funct7) illegal = 1'b1; else alu_ctrl = ALU_XOR;
      3'b101: if (funct7) illegal = 1'b1; else alu_ctrl = ALU_SRL;
      3'b110: if (is_r_s && funct7) illegal = 1'b1; else alu_ctrl = ALU_OR;
      3'b111: if (is_r_s && funct7) illegal = 1'b1; else alu_ctrl = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: one datapath step per state, req/ready memory
// handshake with timeout, sticky trap flags and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  multicycle_ctrl_if.master   bus
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? {WAIT_W{1'b0}} : WAIT_W'(TIMEOUT - 1);

  state_t            state_r;
  state_t            state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              illegal_r;
  logic              mem_err_r;
  logic [CNT_W-1:0]  instret_r;

  logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s;
  logic [2:0] alu_control_s, imm_src_s;
  logic       retire_s, timeout_s, waiting_s;
  logic [2:0] dec_alu_s;
  logic       dec_illegal_s;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .op       (bus.op_i),
    .funct3   (bus.funct3_i),
    .funct7   (bus.funct7_i),
    .alu_ctrl (dec_alu_s),
    .illegal  (dec_illegal_s)
  );

  assign waiting_s = is_mem_state(state_r) && !bus.mem_ready_i;
  // The timeout fires on the last tolerated idle cycle so the request drops right after.
  assign timeout_s = (TIMEOUT != 0) && waiting_s && (wait_cnt_r == WAIT_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-state strobe decode.
  always_comb begin
    state_next_s  = state_r;
    mem_req_s     = 1'b0;
    mem_write_s   = 1'b0;
    adr_src_s     = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    alu_src_a_s   = SRCA_PC;
    alu_src_b_s   = SRCB_RS2;
    alu_control_s = ALU_ADD;
    imm_src_s     = IMM_I;
    result_src_s  = RES_ALUOUT;
    retire_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALU;
        if (timeout_s) begin
          state_next_s = S_TRAP;
        end else if (bus.mem_ready_i) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        imm_src_s   = IMM_B;
        case (bus.op_i)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_R:              state_next_s = S_EXEC_R;
          OP_I:              state_next_s = S_EXEC_I;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_JAL;
          default:           state_next_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        if (bus.op_i == OP_STORE) begin
          imm_src_s    = IMM_S;
          state_next_s = S_MEMWR;
        end else begin
          imm_src_s    = IMM_I;
          state_next_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (timeout_s) state_next_s = S_TRAP;
        else if (bus.mem_ready_i) state_next_s = S_MEMWB;
        else state_next_s = S_MEMRD;
      end
      S_MEMWB: begin
        result_src_s = RES_MEM;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        if (timeout_s) begin
          state_next_s = S_TRAP;
        end else if (bus.mem_ready_i) begin
          retire_s     = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWR;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a_s   = SRCA_RS1;
        alu_src_b_s   = (state_r == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
        alu_control_s = dec_alu_s;
        if (dec_illegal_s) state_next_s = S_TRAP;
        else state_next_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s   = SRCA_RS1;
        alu_control_s = ALU_SUB;
        case (bus.funct3_i)
          3'b000: begin
            pc_write_s   = bus.Zero_i;
            retire_s     = 1'b1;
            state_next_s = S_FETCH;
          end
          3'b001: begin
            pc_write_s   = !bus.Zero_i;
            retire_s     = 1'b1;
            state_next_s = S_FETCH;
          end
          default: state_next_s = S_TRAP;
        endcase
      end
      S_JAL: begin
        alu_src_a_s  = SRCA_OLDPC;
        alu_src_b_s  = SRCB_FOUR;
        pc_write_s   = 1'b1;
        state_next_s = S_ALUWB;
      end
      S_TRAP:  state_next_s = S_TRAP;
      default: state_next_s = S_TRAP;
    endcase
  end

  // Wait counter, sticky flags and retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      illegal_r  <= 1'b0;
      mem_err_r  <= 1'b0;
      instret_r  <= {CNT_W{1'b0}};
    end else begin
      if (state_next_s != state_r) wait_cnt_r <= {WAIT_W{1'b0}};
      else if ((TIMEOUT != 0) && waiting_s) wait_cnt_r <= wait_cnt_r + 1'b1;
      else wait_cnt_r <= wait_cnt_r;
      if (state_next_s == S_TRAP) illegal_r <= 1'b1;
      if (timeout_s) mem_err_r <= 1'b1;
      if (retire_s) instret_r <= instret_r + 1'b1;
    end
  end

  assign bus.mem_req_o    = mem_req_s;
  assign bus.MemWrite_o   = mem_write_s;
  assign bus.AdrSrc_o     = adr_src_s;
  assign bus.IRWrite_o    = ir_write_s;
  assign bus.PCWrite_o    = pc_write_s;
  assign bus.RegWrite_o   = reg_write_s;
  assign bus.ALUSrcA_o    = alu_src_a_s;
  assign bus.ALUSrcB_o    = alu_src_b_s;
  assign bus.ALUControl_o = alu_control_s;
  assign bus.ImmSrc_o     = imm_src_s;
  assign bus.ResultSrc_o  = result_src_s;
  assign bus.illegal_o    = illegal_r;
  assign bus.mem_err_o    = mem_err_r;
  assign bus.instret_o    = instret_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expected step sequences
// are built from the instruction class and checked every cycle.
module tb_multicycle_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();

  multicycle_ctrl #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic req, mw, adr, irw, pcw, rw;
    logic [1:0] a, b;
    logic [2:0] alu, imm;
    logic [1:0] res;
  } strb_t;

  localparam strb_t NONE = 18'd0;

  int checks   = 0;
  int failures = 0;
  int req_adr_cycles = 0;
  logic          exp_ill = 1'b0;
  logic          exp_err = 1'b0;
  logic [CW-1:0] exp_ret = '0;

  function automatic strb_t v_fetch(input logic rdy);
    strb_t s = NONE; s.req = 1'b1; s.b = 2'b10; s.res = 2'b10; s.irw = rdy; s.pcw = rdy; return s;
  endfunction
  function automatic strb_t v_decode();
    strb_t s = NONE; s.a = 2'b01; s.b = 2'b01; s.imm = 3'b001; return s;
  endfunction
  function automatic strb_t v_memadr(input logic st);
    strb_t s = NONE; s.a = 2'b10; s.b = 2'b01; s.imm = st ? 3'b010 : 3'b000; return s;
  endfunction
  function automatic strb_t v_memrd();
    strb_t s = NONE; s.req = 1'b1; s.adr = 1'b1; return s;
  endfunction
  function automatic strb_t v_memwb();
    strb_t s = NONE; s.res = 2'b01; s.rw = 1'b1; return s;
  endfunction
  function automatic strb_t v_memwr();
    strb_t s = NONE; s.req = 1'b1; s.mw = 1'b1; s.adr = 1'b1; return s;
  endfunction
  function automatic strb_t v_exec(input logic is_r, input logic [2:0] alu);
    strb_t s = NONE; s.a = 2'b10; s.b = is_r ? 2'b00 : 2'b01; s.alu = alu; return s;
  endfunction
  function automatic strb_t v_aluwb();
    strb_t s = NONE; s.rw = 1'b1; return s;
  endfunction
  function automatic strb_t v_branch(input logic pcw);
    strb_t s = NONE; s.a = 2'b10; s.alu = 3'b001; s.pcw = pcw; return s;
  endfunction
  function automatic strb_t v_jal();
    strb_t s = NONE; s.a = 2'b01; s.b = 2'b10; s.pcw = 1'b1; return s;
  endfunction

  // Mnemonic table: which funct combinations exist and which ALU op each needs.
  function automatic logic ref_alu(input logic is_r, input logic [2:0] f3, input logic f7,
                                   output logic [2:0] code);
    logic ok = 1'b1;
    code = 3'b000;
    if (is_r) begin
      case ({f7, f3})
        4'b0000: code = 3'b000;
        4'b1000: code = 3'b001;
        4'b0111: code = 3'b010;
        4'b0110: code = 3'b011;
        4'b0100: code = 3'b100;
        4'b0010: code = 3'b101;
        4'b0001: code = 3'b110;
        4'b0101: code = 3'b111;
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000: code = 3'b000;
        3'b111: code = 3'b010;
        3'b110: code = 3'b011;
        3'b100: code = 3'b100;
        3'b010: code = 3'b101;
        3'b001: if (!f7) code = 3'b110; else ok = 1'b0;
        3'b101: if (!f7) code = 3'b111; else ok = 1'b0;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive ready, then compare every output against the model.
  task automatic step(input string nm, input strb_t e, input logic rdy);
    strb_t a;
    @(negedge clk);
    bus.mem_ready_i = rdy;
    #1;
    a = {bus.mem_req_o, bus.MemWrite_o, bus.AdrSrc_o, bus.IRWrite_o, bus.PCWrite_o,
         bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUControl_o, bus.ImmSrc_o,
         bus.ResultSrc_o};
    if (a.req && a.adr) req_adr_cycles++;
    chk({nm, "_strobes"}, {14'd0, a}, {14'd0, e});
    chk({nm, "_illegal"}, {31'd0, bus.illegal_o}, {31'd0, exp_ill});
    chk({nm, "_mem_err"}, {31'd0, bus.mem_err_o}, {31'd0, exp_err});
    chk({nm, "_instret"}, bus.instret_o, exp_ret);
  endtask

  task automatic wait_phase(input string nm, input strb_t e_wait, input strb_t e_go,
                            input int nwait, output bit tmo);
    tmo = 1'b0;
    for (int w = 0; w < nwait; w++) begin
      step({nm, "_wait"}, e_wait, 1'b0);
      if (w + 1 == TMO) begin
        exp_err = 1'b1;
        exp_ill = 1'b1;
        tmo     = 1'b1;
        return;
      end
    end
    step(nm, e_go, 1'b1);
  endtask

  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input int fw, input int mw);
    bit tmo;
    logic ok;
    logic [2:0] alu;
    bus.op_i = op; bus.funct3_i = f3; bus.funct7_i = f7; bus.Zero_i = z;
    wait_phase({nm, "_fetch"}, v_fetch(1'b0), v_fetch(1'b1), fw, tmo);
    if (tmo) return;
    step({nm, "_decode"}, v_decode(), 1'b1);
    case (op)
      7'b0000011: begin
        step({nm, "_memadr"}, v_memadr(1'b0), 1'b1);
        wait_phase({nm, "_memrd"}, v_memrd(), v_memrd(), mw, tmo);
        if (!tmo) begin
          step({nm, "_memwb"}, v_memwb(), 1'b1);
          exp_ret = exp_ret + 32'd1;
        end
      end
      7'b0100011: begin
        step({nm, "_memadr"}, v_memadr(1'b1), 1'b1);
        wait_phase({nm, "_memwr"}, v_memwr(), v_memwr(), mw, tmo);
        if (!tmo) exp_ret = exp_ret + 32'd1;
      end
      7'b0110011, 7'b0010011: begin
        ok = ref_alu(op == 7'b0110011, f3, f7, alu);
        step({nm, "_exec"}, v_exec(op == 7'b0110011, alu), 1'b1);
        if (ok) begin
          step({nm, "_aluwb"}, v_aluwb(), 1'b1);
          exp_ret = exp_ret + 32'd1;
        end else begin
          exp_ill = 1'b1;
        end
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          step({nm, "_branch"}, v_branch((f3 == 3'b000) ? z : !z), 1'b1);
          exp_ret = exp_ret + 32'd1;
        end else begin
          step({nm, "_branch"}, v_branch(1'b0), 1'b1);
          exp_ill = 1'b1;
        end
      end
      7'b1101111: begin
        step({nm, "_jal"}, v_jal(), 1'b1);
        step({nm, "_aluwb"}, v_aluwb(), 1'b1);
        exp_ret = exp_ret + 32'd1;
      end
      default: exp_ill = 1'b1;
    endcase
  endtask

  task automatic trap_hold(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm, NONE, i[0]);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_ill = 1'b0;
    exp_err = 1'b0;
    exp_ret = '0;
    chk({nm, "_rst_instret"}, bus.instret_o, 32'd0);
    chk({nm, "_rst_illegal"}, {31'd0, bus.illegal_o}, 32'd0);
    chk({nm, "_rst_mem_err"}, {31'd0, bus.mem_err_o}, 32'd0);
    chk({nm, "_rst_fetch_req"}, {31'd0, bus.mem_req_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op_i = 7'd0; bus.funct3_i = 3'd0; bus.funct7_i = 1'b0;
    bus.Zero_i = 1'b0; bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("por");

    run("addi", 7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);
    settle(); chk("addi_instret_lit", bus.instret_o, 32'd1);

    req_adr_cycles = 0;
    run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
    settle(); chk("lw_req_adr_lit", req_adr_cycles, 32'd4);
    chk("lw_instret_lit", bus.instret_o, 32'd2);

    run("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 2, 1);
    run("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    run("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    run("and",  7'b0110011, 3'b111, 1'b0, 1'b0, 1, 0);
    run("or",   7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
    run("xor",  7'b0110011, 3'b100, 1'b0, 1'b0, 0, 0);
    run("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0);
    run("sll",  7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0);
    run("srl",  7'b0110011, 3'b101, 1'b0, 1'b0, 0, 0);
    run("addi_neg", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
    run("andi", 7'b0010011, 3'b111, 1'b1, 1'b0, 0, 0);
    run("xori", 7'b0010011, 3'b100, 1'b1, 1'b0, 0, 0);
    run("slli", 7'b0010011, 3'b001, 1'b0, 1'b0, 0, 0);
    run("srli", 7'b0010011, 3'b101, 1'b0, 1'b0, 0, 0);
    run("beq_taken",  7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    run("bne_nottkn", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
    run("beq_nottkn", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    run("bne_taken",  7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
    settle(); chk("branches_instret_lit", bus.instret_o, 32'd20);
    run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
    settle(); chk("jal_instret_lit", bus.instret_o, 32'd21);

    run("sra", 7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0);
    trap_hold("sra_trap", 3);
    chk("sra_illegal_lit", {31'd0, bus.illegal_o}, 32'd1);
    do_reset("after_sra");

    run("sltiu", 7'b0010011, 3'b011, 1'b0, 1'b0, 0, 0);
    trap_hold("sltiu_trap", 2);
    do_reset("after_sltiu");

    run("blt", 7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0);
    trap_hold("blt_trap", 2);
    do_reset("after_blt");

    run("ecall", 7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
    trap_hold("ecall_trap", 4);
    chk("ecall_illegal_lit", {31'd0, bus.illegal_o}, 32'd1);
    chk("ecall_req_lit", {31'd0, bus.mem_req_o}, 32'd0);
    do_reset("after_ecall");

    run("fetch_tmo", 7'b0010011, 3'b000, 1'b0, 1'b0, 4, 0);
    trap_hold("fetch_tmo_trap", 3);
    chk("fetch_tmo_err_lit", {31'd0, bus.mem_err_o}, 32'd1);
    do_reset("after_fetch_tmo");

    run("fetch_wait3", 7'b0010011, 3'b000, 1'b0, 1'b0, 3, 0);
    settle(); chk("fetch_wait3_instret_lit", bus.instret_o, 32'd1);

    run("sw_tmo", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 6);
    trap_hold("sw_tmo_trap", 3);
    chk("sw_tmo_err_lit", {31'd0, bus.mem_err_o}, 32'd1);
    chk("sw_tmo_instret_lit", bus.instret_o, 32'd1);
    do_reset("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
